// File: rtl/gcd_feeder.sv
// Operand FIFO plus issue FSM feeding a single gcd_core and holding its result for the consumer.
// Optional feature macro: GCD_ZERO_BYPASS_EN (zero operand pairs resolved locally without the core).
module gcd_feeder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  output logic                     core_start,
  output logic [31:0]              core_a,
  output logic [31:0]              core_b,
  input  logic                     core_ready,
  input  logic                     core_done,
  input  logic [31:0]              core_r,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_r,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  pair_t            mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [31:0]      core_a_q, core_a_d;
  logic [31:0]      core_b_q, core_b_d;
  logic [31:0]      out_r_q, out_r_d;
  logic             full, empty, push, pop;
  pair_t            head;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = in_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  // Storage carries no reset; emptiness is defined by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{a: in_a, b: in_b};
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    core_a_d = core_a_q;
    core_b_d = core_b_q;
    out_r_d  = out_r_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
`ifdef GCD_ZERO_BYPASS_EN
          // gcd(x,0) == x, so a zero operand never needs the core
          if (head.a == '0 || head.b == '0) begin
            pop     = 1'b1;
            out_r_d = head.a | head.b;
            state_d = HOLD;
          end else
`endif
          if (core_ready) begin
            pop      = 1'b1;
            core_a_d = head.a;
            core_b_d = head.b;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (core_done) begin
          out_r_d = core_r;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      core_a_q <= '0;
      core_b_q <= '0;
      out_r_q  <= '0;
    end else begin
      state_q  <= state_d;
      core_a_q <= core_a_d;
      core_b_q <= core_b_d;
      out_r_q  <= out_r_d;
    end
  end

  assign in_ready   = !full;
  assign core_start = (state_q == ISSUE);
  assign core_a     = core_a_q;
  assign core_b     = core_b_q;
  assign out_valid  = (state_q == HOLD);
  assign out_r      = out_r_q;
  assign count      = cnt_q;

endmodule

// File: tb/tb_gcd_feeder.sv
// Directed bench for gcd_feeder with a behavioural gcd_core of configurable latency.
module tb_gcd_feeder;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, core_start, core_ready, core_done;
  logic        out_valid, out_ready;
  logic [31:0] in_a, in_b, core_a, core_b, core_r, out_r;
  logic [2:0]  count;

  gcd_feeder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .core_start(core_start), .core_a(core_a),
    .core_b(core_b), .core_ready(core_ready), .core_done(core_done),
    .core_r(core_r), .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .count(count)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int starts, core_lat, cnt;
  bit busy, core_stall;
  logic [31:0] ca, cb, last_a, last_b;
  logic [31:0] results[$];

  function automatic logic [31:0] gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x = a, y = b, t;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // Handshakes are recorded before the edge that samples them; the core model reacts after it.
  task automatic step();
    if (rst_n && out_valid && out_ready) results.push_back(out_r);
    @(posedge clk); #1;
    core_done = 1'b0;
    if (busy) begin
      cnt--;
      if (cnt == 0) begin core_done = 1'b1; core_r = gcd(ca, cb); busy = 1'b0; end
    end
    if (core_start) begin
      starts++; ca = core_a; cb = core_b; last_a = core_a; last_b = core_b;
      busy = 1'b1; cnt = core_lat;
    end
    core_ready = !busy && !core_stall;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_a = a; in_b = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    for (int i = 0; i < 80 && !out_valid; i++) step();
    nvec++;
    if (out_valid !== 1'b1) begin nerr++; $display("FAIL %s_timeout: out_valid=%b expected 1", name, out_valid); end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    core_done = 1'b0; core_r = '0; core_ready = 1'b0; busy = 1'b0; starts = 0;
    results.delete();
    step(); step();
    rst_n = 1'b1;
    step();
    starts = 0;
  endtask

  task automatic test_reset();
    core_stall = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; core_done = 1'b0; core_ready = 1'b0;
    step(); step();
    nvec++; if (count !== 3'd0)      begin nerr++; $display("FAIL rst_count: got %0d expected 0", count); end
    nvec++; if (out_valid !== 1'b0)  begin nerr++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    nvec++; if (core_start !== 1'b0) begin nerr++; $display("FAIL rst_core_start: got %b expected 0", core_start); end
    nvec++; if (out_r !== 32'd0)     begin nerr++; $display("FAIL rst_out_r: got %0d expected 0", out_r); end
    nvec++; if ({core_a, core_b} !== 64'd0) begin nerr++; $display("FAIL rst_core_ab: got %0d,%0d expected 0,0", core_a, core_b); end
    rst_n = 1'b1;
    step();
    nvec++; if (in_ready !== 1'b1)   begin nerr++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_single();
    core_lat = 6; do_reset();
    push(35, 25);
    nvec++; if (count !== 3'd1)      begin nerr++; $display("FAIL single_count: got %0d expected 1", count); end
    nvec++; if (core_start !== 1'b0) begin nerr++; $display("FAIL single_early_start: got %b expected 0", core_start); end
    step();  // pop edge; start is then sampled by the core at the following edge
    nvec++; if (core_start !== 1'b1) begin nerr++; $display("FAIL single_start: got %b expected 1", core_start); end
    nvec++; if (count !== 3'd0)      begin nerr++; $display("FAIL single_count_pop: got %0d expected 0", count); end
    step();
    nvec++; if (core_start !== 1'b0) begin nerr++; $display("FAIL single_start_pulse: got %b expected 0", core_start); end
    wait_out("single");
    nvec++; if (out_r !== 32'd5)     begin nerr++; $display("FAIL single_out_r: got %0d expected 5", out_r); end
    nvec++; if (starts !== 1)        begin nerr++; $display("FAIL single_starts: got %0d expected 1", starts); end
    nvec++; if (last_a !== 32'd35 || last_b !== 32'd25) begin nerr++; $display("FAIL single_core_ab: got %0d,%0d expected 35,25", last_a, last_b); end
    nvec++; if (core_a !== 32'd35 || core_b !== 32'd25) begin nerr++; $display("FAIL single_core_ab_hold: got %0d,%0d expected 35,25", core_a, core_b); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    nvec++; if (out_valid !== 1'b0)  begin nerr++; $display("FAIL single_release: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [3] = '{32'd8, 32'd3, 32'd5};
    core_lat = 3; do_reset();
    out_ready = 1'b1;
    push(128, 72); push(24, 15); push(35, 25);
    repeat (60) step();
    nvec++; if (results.size() !== 3) begin nerr++; $display("FAIL b2b_nres: got %0d expected 3", results.size()); end
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (i >= results.size() || results[i] !== exp[i]) begin
        nerr++; $display("FAIL b2b_res%0d: got %0d expected %0d", i, (i < results.size()) ? results[i] : 32'hx, exp[i]);
      end
    end
    nvec++; if (starts !== 3) begin nerr++; $display("FAIL b2b_starts: got %0d expected 3", starts); end
    out_ready = 1'b0;
  endtask

  task automatic test_fill();
    logic [31:0] exp [4] = '{32'd4, 32'd3, 32'd2, 32'd7};
    core_lat = 3; core_stall = 1'b1; do_reset();
    push(12, 8); push(9, 6); push(10, 4); push(14, 21);
    nvec++; if (count !== 3'd4)     begin nerr++; $display("FAIL fill_count: got %0d expected 4", count); end
    nvec++; if (in_ready !== 1'b0)  begin nerr++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
    push(50, 25);
    nvec++; if (count !== 3'd4)     begin nerr++; $display("FAIL fill_drop_count: got %0d expected 4", count); end
    nvec++; if (starts !== 0)       begin nerr++; $display("FAIL fill_no_start: got %0d expected 0", starts); end
    core_stall = 1'b0; out_ready = 1'b1;
    repeat (80) step();
    nvec++; if (results.size() !== 4) begin nerr++; $display("FAIL fill_nres: got %0d expected 4", results.size()); end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (i >= results.size() || results[i] !== exp[i]) begin
        nerr++; $display("FAIL fill_res%0d: got %0d expected %0d", i, (i < results.size()) ? results[i] : 32'hx, exp[i]);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    core_lat = 3; do_reset();
    push(128, 72); push(24, 15);
    wait_out("bp_first");
    nvec++; if (out_r !== 32'd8) begin nerr++; $display("FAIL bp_first: got %0d expected 8", out_r); end
    repeat (10) step();
    nvec++; if (out_valid !== 1'b1 || out_r !== 32'd8) begin nerr++; $display("FAIL bp_hold: got v=%b r=%0d expected v=1 r=8", out_valid, out_r); end
    nvec++; if (starts !== 1)    begin nerr++; $display("FAIL bp_starts_held: got %0d expected 1", starts); end
    nvec++; if (count !== 3'd1)  begin nerr++; $display("FAIL bp_count: got %0d expected 1", count); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    wait_out("bp_second");
    nvec++; if (out_r !== 32'd3) begin nerr++; $display("FAIL bp_second: got %0d expected 3", out_r); end
    nvec++; if (starts !== 2)    begin nerr++; $display("FAIL bp_starts: got %0d expected 2", starts); end
  endtask

  task automatic test_zero_bypass();
    int exp_starts;
`ifdef GCD_ZERO_BYPASS_EN
    exp_starts = 0;
`else
    exp_starts = 2;
`endif
    core_lat = 3; do_reset();
    out_ready = 1'b1;
    push(0, 17); push(9, 0);
    repeat (40) step();
    nvec++; if (results.size() !== 2) begin nerr++; $display("FAIL zero_nres: got %0d expected 2", results.size()); end
    nvec++; if (results.size() < 1 || results[0] !== 32'd17) begin nerr++; $display("FAIL zero_res0: got %0d expected 17", (results.size() > 0) ? results[0] : 32'hx); end
    nvec++; if (results.size() < 2 || results[1] !== 32'd9)  begin nerr++; $display("FAIL zero_res1: got %0d expected 9", (results.size() > 1) ? results[1] : 32'hx); end
    nvec++; if (starts !== exp_starts) begin nerr++; $display("FAIL zero_starts: got %0d expected %0d", starts, exp_starts); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    core_lat = 20; do_reset();
    push(35, 25); step(); step(); step();
    nvec++; if (starts !== 1) begin nerr++; $display("FAIL mid_started: got %0d expected 1", starts); end
    rst_n = 1'b0; step();
    nvec++; if (out_valid !== 1'b0 || core_start !== 1'b0 || out_r !== 32'd0 || core_a !== 32'd0 || core_b !== 32'd0 || count !== 3'd0 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL mid_reset_outs: got v=%b s=%b r=%0d a=%0d b=%0d c=%0d rdy=%b expected 0,0,0,0,0,0,1",
                       out_valid, core_start, out_r, core_a, core_b, count, in_ready);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin step(); if (out_valid) seen = 1'b1; end
    nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL mid_late_done: out_valid seen=%b expected 0", seen); end
    nvec++; if (starts !== 1)  begin nerr++; $display("FAIL mid_no_restart: got %0d expected 1", starts); end
    out_ready = 1'b0;
  endtask

  initial begin
    core_lat = 3; core_stall = 1'b0; busy = 1'b0; starts = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_backpressure();
    test_zero_bypass();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
